// File: rtl/dec_onehot_seq_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
//   Shared types and helpers for the dec_onehot_seq decoder family.
//   - state_t : FSM states (IDLE, PULSE)
//   - CNT_W   : strobe-length counter width
//   - MAX_OUT : widest output vector any select width can address (2**8)
//   - onehot(): decode of a select against n valid outputs; zero when the
//               select is out of range
//   Optional feature macro used by the decoder: DEC_ERR_EN (err output).
// ---------------------------------------------------------------------------
package dec_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  localparam int CNT_W   = 8;
  localparam int MAX_OUT = 256;

  // Returns a MAX_OUT-wide vector; callers size-cast it down to NUM_OUT.
  // Only indices below n are ever set, so an out-of-range select gives zero.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [7:0] sel, input int n);
    logic [MAX_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if ((i < n) && (int'(sel) == i)) begin
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_onehot_seq_if.sv
// ---------------------------------------------------------------------------
// dec_onehot_seq_if
//   Bundles the decoder's control/select inputs and decoded outputs.
//   master : the block driving selects (e, mode, in_valid, a)
//   slave  : the decoder (drives in_ready, y, busy and, optionally, err)
//   Signals:
//     e        decoder enable
//     mode     0 = LEVEL, 1 = PULSE
//     in_valid select valid (PULSE mode)
//     in_ready decoder can accept a select
//     a        select, SEL_W bits
//     y        one-hot / all-zero output, NUM_OUT bits
//     busy     strobe in progress
//     err      out-of-range flag, present only when DEC_ERR_EN is defined
// ---------------------------------------------------------------------------
interface dec_onehot_seq_if #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4
);
  logic               e;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   a;
  logic [NUM_OUT-1:0] y;
  logic               busy;
`ifdef DEC_ERR_EN
  logic               err;

  modport master (output e, mode, in_valid, a, input in_ready, y, busy, err);
  modport slave  (input e, mode, in_valid, a, output in_ready, y, busy, err);
`else
  modport master (output e, mode, in_valid, a, input in_ready, y, busy);
  modport slave  (input e, mode, in_valid, a, output in_ready, y, busy);
`endif
endinterface

// File: rtl/dec_onehot_seq_timer.sv
// ---------------------------------------------------------------------------
// dec_pulse_timer
//   Down-counter that times the strobe length of the decoder's PULSE mode.
//   Ports:
//     clk      in  clock, rising edge
//     rst_n    in  asynchronous active-low reset
//     load     in  load load_val (takes priority over abort)
//     load_val in  CNT_W-bit start value (strobe length minus one)
//     abort    in  force the count to zero
//     done     out comb, 1 when the count is zero
//   Has no dependency on DEC_ERR_EN.
// ---------------------------------------------------------------------------
module dec_pulse_timer
  import dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             abort,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (abort) begin
      cnt_next = '0;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/dec_onehot_seq.sv
// ---------------------------------------------------------------------------
// dec_onehot_seq
//   Registered N-to-M one-hot decoder with two modes:
//     LEVEL (mode=0): y follows e ? onehot(a) : 0 with one clock of latency.
//     PULSE (mode=1): an accepted in-range select drives a one-hot strobe for
//                     exactly PULSE_LEN cycles; dropping e aborts the strobe.
//   Parameters: SEL_W (1..8), NUM_OUT (2..2**SEL_W), PULSE_LEN (1..255).
//   Ports:
//     clk   in  clock, rising edge
//     rst_n in  asynchronous active-low reset
//     bus   dec_onehot_seq_if.slave (e, mode, in_valid, a -> in_ready, y,
//           busy, err)
//   Optional feature: DEC_ERR_EN adds the registered one-cycle err flag for
//   out-of-range selects (LEVEL with e=1, or an accepted PULSE select).
// ---------------------------------------------------------------------------
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int NUM_OUT   = 4,
  parameter int PULSE_LEN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dec_onehot_seq_if.slave     bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_LEN - 1);

  state_t             state_reg, state_next;
  logic [NUM_OUT-1:0] y_reg, y_next;
  logic               busy_reg, busy_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;

  logic [NUM_OUT-1:0] dec_a;
  logic [NUM_OUT-1:0] dec_sel;
  logic               a_in_range;
  logic               accept;
  logic               timer_load;
  logic               timer_abort;
  logic               timer_done;

  // An in-range select always decodes to a single set bit, so range checking
  // falls out of the decode itself rather than a separate comparator.
  assign dec_a      = NUM_OUT'(onehot(8'(bus.a), NUM_OUT));
  assign dec_sel    = NUM_OUT'(onehot(8'(sel_reg), NUM_OUT));
  assign a_in_range = |dec_a;

  assign bus.in_ready = (state_reg == IDLE);
  assign accept       = (state_reg == IDLE) && bus.mode && bus.in_valid && bus.e;

`ifdef DEC_ERR_EN
  logic err_reg, err_next;
`endif

  always_comb begin
    state_next  = state_reg;
    y_next      = '0;
    busy_next   = 1'b0;
    sel_next    = sel_reg;
    timer_load  = 1'b0;
    timer_abort = 1'b0;
`ifdef DEC_ERR_EN
    err_next    = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (!bus.mode) begin
          y_next = bus.e ? dec_a : '0;
`ifdef DEC_ERR_EN
          err_next = bus.e && !a_in_range;
`endif
        end else if (accept) begin
          if (a_in_range) begin
            sel_next   = bus.a;
            y_next     = dec_a;
            busy_next  = 1'b1;
            timer_load = 1'b1;
            state_next = PULSE;
          end
`ifdef DEC_ERR_EN
          else begin
            err_next = 1'b1;
          end
`endif
        end
      end
      PULSE: begin
        if (!bus.e) begin
          // Abort: strobe remainder is discarded and the timer cleared.
          timer_abort = 1'b1;
          state_next  = IDLE;
        end else if (timer_done) begin
          state_next = IDLE;
        end else begin
          y_next    = dec_sel;
          busy_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      busy_reg  <= 1'b0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      busy_reg  <= busy_next;
      sel_reg   <= sel_next;
    end
  end

`ifdef DEC_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end
  assign bus.err = err_reg;
`endif

  assign bus.y    = y_reg;
  assign bus.busy = busy_reg;

  dec_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (LOAD_VAL),
    .abort    (timer_abort),
    .done     (timer_done)
  );

endmodule

// File: tb/tb_dec_onehot_seq.sv
// ---------------------------------------------------------------------------
// tb_dec_onehot_seq
//   Directed steps followed by randomized traffic, each cycle compared with
//   a behavioural model of the decoder. Uses NUM_OUT=3 with a 2-bit select
//   so select value 3 is out of range. err is checked when DEC_ERR_EN is set.
// ---------------------------------------------------------------------------
module tb_dec_onehot_seq;

  localparam int SEL_W     = 2;
  localparam int NUM_OUT   = 3;
  localparam int PULSE_LEN = 3;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: a strobe is "on" for a counted number of cycles.
  logic [NUM_OUT-1:0] m_y;
  logic               m_busy;
  logic               m_err;
  int                 m_hi;

  dec_onehot_seq_if #(.SEL_W(SEL_W), .NUM_OUT(NUM_OUT)) bif ();

  dec_onehot_seq #(
    .SEL_W     (SEL_W),
    .NUM_OUT   (NUM_OUT),
    .PULSE_LEN (PULSE_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_y    = '0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_hi   = 0;
  endtask

  // One clock edge of the model, from the inputs presented before the edge.
  task automatic model_edge();
    logic in_rng;
    in_rng = (int'(bif.a) < NUM_OUT);
    m_err  = 1'b0;
    if (m_busy) begin
      if (!bif.e || m_hi == PULSE_LEN) begin
        m_busy = 1'b0;
        m_y    = '0;
      end else begin
        m_hi++;
      end
    end else if (!bif.mode) begin
      m_y   = (bif.e && in_rng) ? (NUM_OUT'(1) << bif.a) : '0;
      m_err = bif.e && !in_rng;
    end else begin
      m_y = '0;
      if (bif.in_valid && bif.e) begin
        if (in_rng) begin
          m_busy = 1'b1;
          m_hi   = 1;
          m_y    = NUM_OUT'(1) << bif.a;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".y"}, 32'(bif.y), 32'(m_y));
    chk({tag, ".busy"}, 32'(bif.busy), 32'(m_busy));
    chk({tag, ".in_ready"}, 32'(bif.in_ready), 32'(!m_busy));
    chk({tag, ".onehot"}, 32'($countones(bif.y) <= 1), 32'd1);
`ifdef DEC_ERR_EN
    chk({tag, ".err"}, 32'(bif.err), 32'(m_err));
`endif
    $display("%s: e=%0b mode=%0b vld=%0b a=%0d -> y=%b busy=%0b rdy=%0b",
             tag, bif.e, bif.mode, bif.in_valid, bif.a, bif.y, bif.busy, bif.in_ready);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic e, input logic mode, input logic vld, input logic [SEL_W-1:0] a);
    bif.e        = e;
    bif.mode     = mode;
    bif.in_valid = vld;
    bif.a        = a;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LEVEL decode with e low, then each select value (3 is out of range).
    drive(1'b0, 1'b0, 1'b0, 2'd2);
    step("level_e0");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, SEL_W'(i));
      step("level");
    end

    // PULSE: accept a=2, strobe PULSE_LEN cycles then release.
    drive(1'b1, 1'b1, 1'b1, 2'd2);
    step("pulse_acc");
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < PULSE_LEN + 1; i++) step("pulse_run");

    // Abort by dropping e mid-strobe, then re-accept.
    drive(1'b1, 1'b1, 1'b1, 2'd1);
    step("abort_acc");
    drive(1'b1, 1'b1, 1'b0, 2'd1);
    step("abort_run");
    drive(1'b0, 1'b1, 1'b0, 2'd1);
    step("abort_drop");
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    step("abort_reacc");
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < PULSE_LEN; i++) step("abort_rerun");

    // Out-of-range accept in PULSE mode, and in_valid with e low.
    drive(1'b1, 1'b1, 1'b1, 2'd3);
    step("pulse_oor");
    drive(1'b0, 1'b1, 1'b1, 2'd1);
    step("pulse_e0");

    // in_valid held high with mode flips during strobes: back-to-back accepts.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i % 5) != 2, 1'b1, SEL_W'(i % 3));
      step("b2b");
    end

    // Asynchronous reset in the middle of a strobe.
    drive(1'b1, 1'b1, 1'b1, 2'd0);
    step("rst_acc");
    drive(1'b1, 1'b1, 1'b0, 2'd0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_after");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 7) != 0,
            ($urandom_range(0, 15) == 0) ? !bif.mode : bif.mode,
            1'($urandom_range(0, 1)),
            SEL_W'($urandom_range(0, 3)));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
